// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder.
//   BYTE_W       - width of one transmitted byte
//   BUSY_TIMEOUT - cycles after a start pulse to wait for tx_busy to rise
//   TMO_W        - width of the busy-timeout down-counter
//   issueState_t - states of the issue FSM
package uart_pkg;

  localparam int BYTE_W       = 8;
  localparam int BUSY_TIMEOUT = 4;
  localparam int TMO_W        = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } issueState_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with one extra pointer bit to tell full
// from empty. Occupancy is the modular pointer difference.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   wr_en, wr_data  - push; ignored while full
//   rd_en, rd_data  - pop; rd_data is the current head (valid when !empty)
//   full, empty     - occupancy flags from the registered pointers
//   level           - occupancy, 0..DEPTH
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             wrAccept;
  logic             rdAccept;

  // Flags come from the registered pointers, so a push is judged against the
  // occupancy at the start of the cycle, before any same-cycle pop.
  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign level    = wrPtr - rdPtr;
  assign rd_data  = mem[rdPtr[AW-1:0]];
  assign wrAccept = wr_en && !full;
  assign rdAccept = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (rdAccept) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers system-side bytes and hands them one at a time to the RS-232
// transmitter, pacing issue from the transmitter's busy output.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset
//   wr_en, wr_data   - push a byte into the buffer
//   full, empty      - buffer occupancy flags
//   level            - buffer occupancy, 0..DEPTH
//   overflow         - sticky, set by a push while full
//   ovf_clr          - clears overflow (a same-cycle overflowing push wins)
//   tx_start         - one-cycle start pulse to the transmitter
//   tx_data          - byte for the transmitter, changes only with tx_start
//   tx_busy          - transmitter busy
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_busy
);

  issueState_t       state;
  logic [TMO_W-1:0]  tmoCnt;
  logic              popEn;
  logic [BYTE_W-1:0] headData;
  logic              txStartReg;
  logic [BYTE_W-1:0] txDataReg;
  logic              ovfReg;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (popEn),
    .rd_data (headData),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // The pop coincides with latching the head into tx_data.
  assign popEn = (state == IDLE) && !empty && !tx_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      txStartReg <= 1'b0;
      txDataReg  <= '0;
      tmoCnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          txStartReg <= 1'b0;
          if (popEn) begin
            txDataReg  <= headData;
            txStartReg <= 1'b1;
            tmoCnt     <= TMO_W'(BUSY_TIMEOUT);
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          txStartReg <= 1'b0;
          // Busy never rising means the transmitter missed the pulse; the
          // popped byte is abandoned so the queue cannot stall forever.
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tmoCnt == TMO_W'(1)) begin
            state <= IDLE;
          end else begin
            tmoCnt <= tmoCnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          txStartReg <= 1'b0;
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          txStartReg <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovfReg <= 1'b0;
    end else if (wr_en && full) begin
      ovfReg <= 1'b1;
    end else if (ovf_clr) begin
      ovfReg <= 1'b0;
    end
  end

  assign tx_start = txStartReg;
  assign tx_data  = txDataReg;
  assign overflow = ovfReg;

endmodule
